// File: rtl/edge_event_arbiter.sv
// ---------------------------------------------------------------------------
// edge_event_arbiter
//
// Watches CHANNELS level inputs for edges. Each channel can hold one pending
// event. A round-robin arbiter offers the pending events, one at a time, on a
// single valid/ready output port.
//
// Parameters
//   CHANNELS : number of monitored lines (2..16)
//   RISE     : 1 = rising edges create events
//   FALL     : 1 = falling edges create events
//   IDW      : width of ev_id, must be >= clog2(CHANNELS)
//
// Ports
//   clk      : system clock, all logic on posedge
//   rst      : asynchronous active-low reset
//   sig_in   : monitored level signals
//   ev_valid : an event is offered on ev_id / ev_rise
//   ev_ready : the consumer accepts the event when high together with ev_valid
//   ev_id    : channel index of the offered event
//   ev_rise  : 1 = rising edge, 0 = falling edge
//   pending  : per-channel flags for events that are waiting
//   overflow : sticky per-channel flags for lost events
//   ovf_clr  : one-cycle pulse that clears all overflow bits
//
// Optional build macro
//   EDGE_EVENT_SYNC_EN : when defined, a 2-flop synchroniser sits in front of
//                        edge detection. Event generation then starts 3 clocks
//                        after reset release.
// ---------------------------------------------------------------------------
module edge_event_arbiter #(
  parameter int CHANNELS = 4,
  parameter bit RISE     = 1'b1,
  parameter bit FALL     = 1'b1,
  parameter int IDW      = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] sig_in,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic [IDW-1:0]      ev_id,
  output logic                ev_rise,
  output logic [CHANNELS-1:0] pending,
  output logic [CHANNELS-1:0] overflow,
  input  logic                ovf_clr
);

  localparam logic [IDW-1:0]      ID_ZERO = {IDW{1'b0}};
  localparam logic [IDW-1:0]      ID_ONE  = {{(IDW-1){1'b0}}, 1'b1};
  localparam logic [IDW-1:0]      ID_LAST = IDW'(CHANNELS - 1);
  localparam logic [CHANNELS-1:0] CH_ZERO = {CHANNELS{1'b0}};
  localparam logic [CHANNELS-1:0] CH_ONE  = {{(CHANNELS-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  // Registers
  state_t              state_r;
  logic                ev_valid_r;
  logic [IDW-1:0]      ev_id_r;
  logic                ev_rise_r;
  logic [IDW-1:0]      rr_r;
  logic [CHANNELS-1:0] pending_r;
  logic [CHANNELS-1:0] pol_r;
  logic [CHANNELS-1:0] overflow_r;
  logic [CHANNELS-1:0] prev_r;
  logic                init_r;

  // Combinational signals
  logic [CHANNELS-1:0] s_s;
  logic [CHANNELS-1:0] rise_s;
  logic [CHANNELS-1:0] fall_s;
  logic [CHANNELS-1:0] edge_s;
  logic                hs_s;
  logic [CHANNELS-1:0] consume_s;
  logic [CHANNELS-1:0] ovf_set_s;
  logic [CHANNELS-1:0] pend_nxt_s;
  logic [CHANNELS-1:0] pol_nxt_s;
  logic [CHANNELS-1:0] ovf_nxt_s;
  logic [CHANNELS-1:0] rot_pend_s;
  logic [CHANNELS-1:0] rot_pol_s;
  logic                found_s;
  logic [IDW-1:0]      sel_s;
  logic                sel_pol_s;
  int                  idx_s;
  state_t              state_nxt_s;
  logic                valid_nxt_s;
  logic [IDW-1:0]      id_nxt_s;
  logic                rise_nxt_s;
  logic [IDW-1:0]      rr_nxt_s;

`ifdef EDGE_EVENT_SYNC_EN
  logic [CHANNELS-1:0] sync1_r;
  logic [CHANNELS-1:0] sync2_r;
  logic [1:0]          settle_r;

  // Two-flop synchroniser on every input line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= CH_ZERO;
      sync2_r <= CH_ZERO;
    end else begin
      sync1_r <= sig_in;
      sync2_r <= sync1_r;
    end
  end

  assign s_s = sync2_r;

  // Edge detection is enabled only after the synchroniser and prev hold real
  // input values, so a line that is high at reset release is not an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      settle_r <= 2'd0;
      init_r   <= 1'b0;
    end else if (!init_r) begin
      if (settle_r == 2'd2) begin
        init_r <= 1'b1;
      end else begin
        settle_r <= settle_r + 2'd1;
      end
    end else begin
      settle_r <= settle_r;
    end
  end
`else
  assign s_s = sig_in;

  // The first clock after reset loads prev. Edges are detected from then on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_r <= 1'b0;
    end else begin
      init_r <= 1'b1;
    end
  end
`endif

  // Previous sampled level, used for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_r <= CH_ZERO;
    end else begin
      prev_r <= s_s;
    end
  end

  // Edge detection, gated by polarity enables and by the init flag.
  assign rise_s = s_s & ~prev_r & {CHANNELS{RISE & init_r}};
  assign fall_s = ~s_s & prev_r & {CHANNELS{FALL & init_r}};
  assign edge_s = rise_s | fall_s;

  // A handshake consumes the event of the channel being offered.
  assign hs_s      = ev_valid_r & ev_ready;
  assign consume_s = hs_s ? (CH_ONE << ev_id_r) : CH_ZERO;

  // A new edge is lost if the slot is still occupied and is not drained in
  // this cycle. The first event wins.
  assign ovf_set_s = edge_s & pending_r & ~consume_s;

  // Next pending and polarity per channel. An edge that coincides with the
  // handshake of its own channel refills the slot with the new polarity.
  always_comb begin
    pend_nxt_s = pending_r;
    pol_nxt_s  = pol_r;
    for (int c = 0; c < CHANNELS; c++) begin
      if (edge_s[c] && !ovf_set_s[c]) begin
        pend_nxt_s[c] = 1'b1;
        pol_nxt_s[c]  = rise_s[c];
      end else if (consume_s[c]) begin
        pend_nxt_s[c] = 1'b0;
      end else begin
      end
    end
  end

  // When ovf_clr and a new overflow hit the same cycle, the set wins.
  assign ovf_nxt_s = ovf_set_s | (ovf_clr ? CH_ZERO : overflow_r);

  // Rotate so that bit 0 is the channel the round-robin pointer names. A
  // plain priority search then gives the fair choice.
  assign rot_pend_s = CHANNELS'({pending_r, pending_r} >> rr_r);
  assign rot_pol_s  = CHANNELS'({pol_r, pol_r} >> rr_r);

  // Round-robin selection: find the first pending channel at or after rr.
  always_comb begin
    found_s   = 1'b0;
    sel_s     = ID_ZERO;
    sel_pol_s = 1'b0;
    idx_s     = 0;
    for (int j = 0; j < CHANNELS; j++) begin
      if (!found_s && rot_pend_s[j]) begin
        found_s   = 1'b1;
        sel_pol_s = rot_pol_s[j];
        idx_s     = int'(rr_r) + j;
        if (idx_s >= CHANNELS) begin
          idx_s = idx_s - CHANNELS;
        end else begin
        end
        sel_s = IDW'(idx_s);
      end else begin
      end
    end
  end

  // Offer FSM: next-state and next output register values.
  always_comb begin
    state_nxt_s = state_r;
    valid_nxt_s = ev_valid_r;
    id_nxt_s    = ev_id_r;
    rise_nxt_s  = ev_rise_r;
    rr_nxt_s    = rr_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          valid_nxt_s = 1'b1;
          id_nxt_s    = sel_s;
          rise_nxt_s  = sel_pol_s;
          state_nxt_s = ST_OFFER;
        end else begin
          valid_nxt_s = 1'b0;
        end
      end
      ST_OFFER: begin
        if (hs_s) begin
          valid_nxt_s = 1'b0;
          rr_nxt_s    = (ev_id_r == ID_LAST) ? ID_ZERO : (ev_id_r + ID_ONE);
          state_nxt_s = ST_IDLE;
        end else begin
          valid_nxt_s = 1'b1;
        end
      end
      default: begin
        valid_nxt_s = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, offer outputs, pointer and per-channel flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      ev_valid_r <= 1'b0;
      ev_id_r    <= ID_ZERO;
      ev_rise_r  <= 1'b0;
      rr_r       <= ID_ZERO;
      pending_r  <= CH_ZERO;
      pol_r      <= CH_ZERO;
      overflow_r <= CH_ZERO;
    end else begin
      state_r    <= state_nxt_s;
      ev_valid_r <= valid_nxt_s;
      ev_id_r    <= id_nxt_s;
      ev_rise_r  <= rise_nxt_s;
      rr_r       <= rr_nxt_s;
      pending_r  <= pend_nxt_s;
      pol_r      <= pol_nxt_s;
      overflow_r <= ovf_nxt_s;
    end
  end

  assign ev_valid = ev_valid_r;
  assign ev_id    = ev_id_r;
  assign ev_rise  = ev_rise_r;
  assign pending  = pending_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// ---------------------------------------------------------------------------
// tb_edge_event_arbiter
//
// Directed bench for edge_event_arbiter. The main instance uses the default
// parameters. A second instance with RISE=0 covers the polarity filter.
// Inputs are driven 1 time unit after posedge, and outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_edge_event_arbiter;

`ifdef EDGE_EVENT_SYNC_EN
  localparam int INIT_TICKS = 3;
  localparam int SYNC_LAT   = 2;
`else
  localparam int INIT_TICKS = 1;
  localparam int SYNC_LAT   = 0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] sig_in;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_id;
  logic       ev_rise;
  logic [3:0] pending;
  logic [3:0] overflow;
  logic       ovf_clr;

  logic [3:0] f_sig_in;
  logic       f_ev_valid;
  logic       f_ev_ready;
  logic [1:0] f_ev_id;
  logic       f_ev_rise;
  logic [3:0] f_pending;
  logic [3:0] f_overflow;
  logic       f_ovf_clr;

  int checks = 0;
  int errors = 0;

  edge_event_arbiter #(.CHANNELS(4), .RISE(1'b1), .FALL(1'b1), .IDW(2)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .ev_id(ev_id), .ev_rise(ev_rise),
    .pending(pending), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  edge_event_arbiter #(.CHANNELS(4), .RISE(1'b0), .FALL(1'b1), .IDW(2)) dut_f (
    .clk(clk), .rst(rst), .sig_in(f_sig_in), .ev_valid(f_ev_valid),
    .ev_ready(f_ev_ready), .ev_id(f_ev_id), .ev_rise(f_ev_rise),
    .pending(f_pending), .overflow(f_overflow), .ovf_clr(f_ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The tick in which an input change is captured as pending.
  task automatic edge_tick();
    repeat (SYNC_LAT) tick();
    tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic [3:0] v);
    rst    = 1'b0;
    sig_in = v;
    tick();
    tick();
    rst = 1'b1;
    repeat (INIT_TICKS) tick();
  endtask

  initial begin
    rst        = 1'b0;
    sig_in     = 4'b0000;
    ev_ready   = 1'b0;
    ovf_clr    = 1'b0;
    f_sig_in   = 4'b0000;
    f_ev_ready = 1'b1;
    f_ovf_clr  = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_valid", 32'(ev_valid), 32'h0);
    check("rst_id", 32'(ev_id), 32'h0);
    check("rst_rise", 32'(ev_rise), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);

    // Single event on channel 2
    rst      = 1'b1;
    ev_ready = 1'b1;
    repeat (INIT_TICKS) tick();
    sig_in = 4'b0100;
    edge_tick();
    check("single_pend", 32'(pending), 32'h4);
    check("single_novalid", 32'(ev_valid), 32'h0);
    tick();
    check("single_valid", 32'(ev_valid), 32'h1);
    check("single_id", 32'(ev_id), 32'h2);
    check("single_rise", 32'(ev_rise), 32'h1);
    tick();
    check("single_done_valid", 32'(ev_valid), 32'h0);
    check("single_done_pend", 32'(pending), 32'h0);

    // Simultaneous rises, then simultaneous falls: order 0..3 each time
    do_reset(4'b0000);
    ev_ready = 1'b1;
    sig_in   = 4'b1111;
    edge_tick();
    check("simul_pend", 32'(pending), 32'hf);
    check("simul_novalid", 32'(ev_valid), 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("simr_valid", 32'(ev_valid), 32'h1);
      check("simr_id", 32'(ev_id), 32'(k));
      check("simr_rise", 32'(ev_rise), 32'h1);
      tick();
      check("simr_gap", 32'(ev_valid), 32'h0);
    end
    check("simr_pend_empty", 32'(pending), 32'h0);
    sig_in = 4'b0000;
    edge_tick();
    check("simf_pend", 32'(pending), 32'hf);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("simf_valid", 32'(ev_valid), 32'h1);
      check("simf_id", 32'(ev_id), 32'(k));
      check("simf_rise", 32'(ev_rise), 32'h0);
      tick();
      check("simf_gap", 32'(ev_valid), 32'h0);
    end

    // Backpressure on channel 1 for 20 cycles
    ev_ready = 1'b0;
    sig_in   = 4'b0010;
    edge_tick();
    for (int k = 0; k < 20; k++) begin
      tick();
      check("bp_valid", 32'(ev_valid), 32'h1);
      check("bp_id", 32'(ev_id), 32'h1);
      check("bp_rise", 32'(ev_rise), 32'h1);
    end
    ev_ready = 1'b1;
    tick();
    check("bp_accept_valid", 32'(ev_valid), 32'h0);
    check("bp_accept_pend", 32'(pending), 32'h0);

    // Overflow on channel 3: the first (rising) event is kept
    ev_ready = 1'b0;
    sig_in   = 4'b1010;
    edge_tick();
    check("ovf_pend1", 32'(pending), 32'h8);
    sig_in = 4'b0010;
    edge_tick();
    check("ovf_pend2", 32'(pending), 32'h8);
    check("ovf_flag", 32'(overflow), 32'h8);
    check("ovf_valid", 32'(ev_valid), 32'h1);
    check("ovf_id", 32'(ev_id), 32'h3);
    check("ovf_rise_kept", 32'(ev_rise), 32'h1);
    ev_ready = 1'b1;
    tick();
    check("ovf_acc_valid", 32'(ev_valid), 32'h0);
    check("ovf_acc_pend", 32'(pending), 32'h0);
    check("ovf_sticky", 32'(overflow), 32'h8);

    // ovf_clr coinciding with a new overflow on channel 0: set wins there
    ev_ready = 1'b0;
    sig_in   = 4'b0011;
    edge_tick();
    sig_in = 4'b0010;
    repeat (SYNC_LAT) tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("clr_setwins", 32'(overflow), 32'h1);
    check("clr_valid_id", 32'(ev_id), 32'h0);
    ev_ready = 1'b1;
    tick();
    check("clr_acc_pend", 32'(pending), 32'h0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("clr_all", 32'(overflow), 32'h0);

`ifndef EDGE_EVENT_SYNC_EN
    // Edge and handshake on the same channel: refilled, no overflow
    ev_ready = 1'b0;
    sig_in   = 4'b0011;
    tick();
    tick();
    check("coin_valid", 32'(ev_valid), 32'h1);
    check("coin_id", 32'(ev_id), 32'h0);
    ev_ready = 1'b1;
    sig_in   = 4'b0010;
    tick();
    check("coin_hs_valid", 32'(ev_valid), 32'h0);
    check("coin_pend", 32'(pending), 32'h1);
    check("coin_noovf", 32'(overflow), 32'h0);
    tick();
    check("coin_reoffer", 32'(ev_valid), 32'h1);
    check("coin_reoffer_rise", 32'(ev_rise), 32'h0);
    tick();
    check("coin_done", 32'(pending), 32'h0);
`endif

    // Lines high through reset release produce no events
    do_reset(4'b1111);
    ev_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("init_novalid", 32'(ev_valid), 32'h0);
    end
    check("init_nopend", 32'(pending), 32'h0);

    // Reset asserted during an offer drops the event at once
    ev_ready = 1'b0;
    sig_in   = 4'b1011;
    edge_tick();
    tick();
    check("mid_valid", 32'(ev_valid), 32'h1);
    check("mid_id", 32'(ev_id), 32'h2);
    check("mid_rise", 32'(ev_rise), 32'h0);
    #2;
    rst = 1'b0;
    #1;
    check("mid_async_valid", 32'(ev_valid), 32'h0);
    check("mid_async_pend", 32'(pending), 32'h0);
    check("mid_async_id", 32'(ev_id), 32'h0);
    tick();
    rst = 1'b1;
    repeat (INIT_TICKS + 3) tick();
    check("mid_after_valid", 32'(ev_valid), 32'h0);
    check("mid_after_pend", 32'(pending), 32'h0);

    // RISE=0 instance: only falling edges generate events
    f_sig_in = 4'b0001;
    edge_tick();
    check("filt_rise_pend", 32'(f_pending), 32'h0);
    tick();
    check("filt_rise_valid", 32'(f_ev_valid), 32'h0);
    f_sig_in = 4'b0000;
    edge_tick();
    check("filt_fall_pend", 32'(f_pending), 32'h1);
    tick();
    check("filt_fall_valid", 32'(f_ev_valid), 32'h1);
    check("filt_fall_id", 32'(f_ev_id), 32'h0);
    check("filt_fall_rise", 32'(f_ev_rise), 32'h0);
    tick();
    check("filt_done", 32'(f_ev_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
